// File: rtl/hermes_route_ctrl_pkg.sv
// Shared Hermes router types: routing modes, port encodings and controller FSM states.
// Port numbers are plain integers so widths can follow the per-instance port count.
package HermesPkg;

    typedef enum logic {HERMES_XY, HERMES_YX} hermes_routing_t;

    localparam int HERMES_EAST   = 0;
    localparam int HERMES_WEST   = 1;
    localparam int HERMES_NORTH  = 2;
    localparam int HERMES_SOUTH  = 3;
    localparam int HERMES_LOCAL0 = 4;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_ROUTE = 5'b00100,
        ST_GRANT = 5'b01000,
        ST_ACK   = 5'b10000
    } hermes_state_t;

    function automatic int hermes_nport(input int nlocal);
        return 4 + nlocal;
    endfunction

endpackage

// File: rtl/hermes_route_ctrl_rr_arbiter.sv
// Round-robin pointer update: picks the first requester strictly after the current
// pointer, wrapping; the current pointer itself is the last candidate checked.
module hermes_rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_sel,
    input  logic         i_en,
    output logic [W-1:0] o_sel
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_sel   = i_sel;
        w_found = 1'b0;
        w_idx   = 0;
        if (i_en) begin
            for (int k = 1; k <= N; k++) begin
                w_idx = (int'(i_sel) + k) % N;
                if (!w_found && i_req[w_idx]) begin
                    o_sel   = W'(w_idx);
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hermes_route_ctrl.sv
// Hermes switch control: arbitrates input headers, computes XY/YX routes, tracks
// output occupancy and drives crossbar selects plus a one-cycle grant acknowledge.
module hermes_route_ctrl
    import HermesPkg::*;
#(
    parameter int                   COORD_W   = 8,
    parameter int                   NLOCAL    = 1,
    parameter int                   FLIT_SIZE = 32,
    parameter logic [2*COORD_W-1:0] ADDRESS   = '0,
    parameter hermes_routing_t      ROUTING   = HERMES_XY,
    localparam int                  NPORT     = hermes_nport(NLOCAL),
    localparam int                  PORT_W    = $clog2(NPORT)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NPORT-1:0]          req_i,
    input  logic [NPORT-1:0]          sending_i,
    input  logic [NPORT*FLIT_SIZE-1:0] data_i,
    output logic [NPORT-1:0]          ack_o,
    output logic [NPORT-1:0]          free_o,
    output logic [NPORT*PORT_W-1:0]   inport_o,
    output logic [NPORT*PORT_W-1:0]   outport_o
);

    localparam int                 LIDX_W = (NLOCAL > 1) ? $clog2(NLOCAL) : 1;
    localparam logic [COORD_W-1:0] MY_X   = ADDRESS[2*COORD_W-1:COORD_W];
    localparam logic [COORD_W-1:0] MY_Y   = ADDRESS[COORD_W-1:0];

    hermes_state_t             r_state;
    logic [PORT_W-1:0]         r_sel;
    logic [PORT_W-1:0]         r_dest;
    logic [NPORT-1:0]          r_free;
    logic [NPORT-1:0]          r_ack;
    logic [NPORT-1:0]          r_sending;
    logic [NPORT*PORT_W-1:0]   r_inport;
    logic [NPORT*PORT_W-1:0]   r_outport;

    logic [PORT_W-1:0]         w_nextSel;
    logic [PORT_W-1:0]         w_dest;
    logic [PORT_W-1:0]         w_localPort;
    logic [PORT_W-1:0]         w_forcePort;
    logic [LIDX_W-1:0]         w_localIdx;
    logic [FLIT_SIZE-1:0]      w_head;
    logic [COORD_W-1:0]        w_tgtX;
    logic [COORD_W-1:0]        w_tgtY;
    logic                      w_force;
    logic [NPORT-1:0]          w_release;
    int                        w_outIdx;

    hermes_rr_arbiter #(
        .N (NPORT),
        .W (PORT_W)
    ) u_arbiter (
        .i_req (req_i),
        .i_sel (r_sel),
        .i_en  (r_state == ST_ARBIT),
        .o_sel (w_nextSel)
    );

    assign w_head      = data_i[int'(r_sel)*FLIT_SIZE +: FLIT_SIZE];
    assign w_tgtX      = w_head[2*COORD_W-1:COORD_W];
    assign w_tgtY      = w_head[COORD_W-1:0];
    assign w_force     = w_head[FLIT_SIZE-1];
    assign w_forcePort = w_head[FLIT_SIZE-2 -: PORT_W];

    generate
        if (NLOCAL > 1) begin : g_localIdx
            assign w_localIdx = w_head[FLIT_SIZE-2-PORT_W -: LIDX_W];
        end else begin : g_singleLocal
            assign w_localIdx = '0;
        end
    endgenerate

    // Out-of-range forced ports or local indices fall back to the first local port.
    always_comb begin
        w_localPort = PORT_W'(HERMES_LOCAL0);
        if (w_force) begin
            if (int'(w_forcePort) < NPORT)
                w_localPort = w_forcePort;
        end else if (int'(w_localIdx) < NLOCAL) begin
            w_localPort = PORT_W'(HERMES_LOCAL0 + int'(w_localIdx));
        end
    end

    always_comb begin
        w_dest = w_localPort;
        if (ROUTING == HERMES_XY) begin
            if (w_tgtX != MY_X)
                w_dest = (w_tgtX > MY_X) ? PORT_W'(HERMES_EAST) : PORT_W'(HERMES_WEST);
            else if (w_tgtY != MY_Y)
                w_dest = (w_tgtY > MY_Y) ? PORT_W'(HERMES_NORTH) : PORT_W'(HERMES_SOUTH);
        end else begin
            if (w_tgtY != MY_Y)
                w_dest = (w_tgtY > MY_Y) ? PORT_W'(HERMES_NORTH) : PORT_W'(HERMES_SOUTH);
            else if (w_tgtX != MY_X)
                w_dest = (w_tgtX > MY_X) ? PORT_W'(HERMES_EAST) : PORT_W'(HERMES_WEST);
        end
    end

    always_comb begin
        w_release = '0;
        w_outIdx  = 0;
        for (int p = 0; p < NPORT; p++) begin
            if (r_sending[p] && !sending_i[p]) begin
                w_outIdx = int'(r_outport[p*PORT_W +: PORT_W]);
                if (w_outIdx < NPORT)
                    w_release[w_outIdx] = 1'b1;
            end
        end
    end

    // The GRANT write to r_free comes after the release merge so it wins on a shared bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_dest    <= '0;
            r_free    <= '1;
            r_ack     <= '0;
            r_sending <= '0;
            r_inport  <= '0;
            r_outport <= '0;
        end else begin
            r_sending <= sending_i;
            r_ack     <= '0;
            r_free    <= r_free | w_release;
            case (r_state)
                ST_IDLE: begin
                    if (|req_i)
                        r_state <= ST_ARBIT;
                end
                ST_ARBIT: begin
                    r_sel   <= w_nextSel;
                    r_state <= ST_ROUTE;
                end
                ST_ROUTE: begin
                    if (r_free[w_dest]) begin
                        r_dest  <= w_dest;
                        r_state <= ST_GRANT;
                    end else begin
                        r_state <= ST_ARBIT;
                    end
                end
                ST_GRANT: begin
                    r_free[r_dest]                              <= 1'b0;
                    r_outport[int'(r_sel)*PORT_W +: PORT_W]     <= r_dest;
                    r_inport[int'(r_dest)*PORT_W +: PORT_W]     <= r_sel;
                    r_ack[r_sel]                                <= 1'b1;
                    r_state                                     <= ST_ACK;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack_o     = r_ack;
    assign free_o    = r_free;
    assign inport_o  = r_inport;
    assign outport_o = r_outport;

endmodule

// File: tb/tb_hermes_route_ctrl.sv
// Scoreboard bench for hermes_route_ctrl: an XY router (1 local) and a YX router (2 locals),
// both at 0x0101; expected grants are queued by the stimulus and popped by per-DUT monitors.
module tb_hermes_route_ctrl;
    import HermesPkg::*;

    typedef struct {
        int port;
        int dest;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nCompared = 0;
    int nFailed   = 0;

    exp_t qA[$];
    exp_t qB[$];
    exp_t eA;
    exp_t eB;

    logic          rstA, rstB;
    logic [4:0]    reqA, sendA, ackA, freeA;
    logic [5*32-1:0] dataA;
    logic [14:0]   inportA, outportA;
    logic [5:0]    reqB, sendB, ackB, freeB;
    logic [6*32-1:0] dataB;
    logic [17:0]   inportB, outportB;

    hermes_route_ctrl #(
        .COORD_W(8), .NLOCAL(1), .FLIT_SIZE(32), .ADDRESS(16'h0101), .ROUTING(HERMES_XY)
    ) dutA (
        .clk_i(clk), .rst_i(rstA), .req_i(reqA), .sending_i(sendA), .data_i(dataA),
        .ack_o(ackA), .free_o(freeA), .inport_o(inportA), .outport_o(outportA)
    );

    hermes_route_ctrl #(
        .COORD_W(8), .NLOCAL(2), .FLIT_SIZE(32), .ADDRESS(16'h0101), .ROUTING(HERMES_YX)
    ) dutB (
        .clk_i(clk), .rst_i(rstB), .req_i(reqB), .sending_i(sendB), .data_i(dataB),
        .ack_o(ackB), .free_o(freeB), .inport_o(inportB), .outport_o(outportB)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        nCompared++;
        if (act != exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mkHead(input bit force_, input logic [2:0] fport,
                                           input bit idx, input logic [15:0] tgt);
        logic [31:0] h;
        h        = '0;
        h[15:0]  = tgt;
        h[31]    = force_;
        h[30:28] = fport;
        h[27]    = idx;
        return h;
    endfunction

    task automatic applyStimulus(input bit isB, input int p, input logic [31:0] head);
        if (isB) begin
            dataB[p*32 +: 32] = head;
            reqB[p]           = 1'b1;
        end else begin
            dataA[p*32 +: 32] = head;
            reqA[p]           = 1'b1;
        end
    endtask

    task automatic waitAckDrop(input bit isB, input int p);
        int n = 0;
        while (n < 40 && !(isB ? ackB[p] : ackA[p])) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40)
            checkOutput($sformatf("ack_timeout_%s_p%0d", isB ? "B" : "A", p),
                        int'(isB ? ackB[p] : ackA[p]), 1);
        if (isB) reqB[p] = 1'b0;
        else     reqA[p] = 1'b0;
        @(negedge clk);
    endtask

    // Each acknowledge must match the oldest queued grant, including the crossbar state it set.
    always @(negedge clk) begin
        if (ackA != '0) begin
            if (qA.size() == 0) begin
                checkOutput("A_unexpected_ack", int'(ackA), 0);
            end else begin
                eA = qA.pop_front();
                checkOutput($sformatf("A_ack_p%0d", eA.port), int'(ackA), 1 << eA.port);
                if (eA.cyc >= 0)
                    checkOutput($sformatf("A_ack_cycle_p%0d", eA.port), cyc, eA.cyc);
                checkOutput($sformatf("A_outport_p%0d", eA.port),
                            int'(outportA[eA.port*3 +: 3]), eA.dest);
                checkOutput($sformatf("A_inport_o%0d", eA.dest),
                            int'(inportA[eA.dest*3 +: 3]), eA.port);
                checkOutput($sformatf("A_free_o%0d", eA.dest), int'(freeA[eA.dest]), 0);
            end
        end
        if (ackB != '0) begin
            if (qB.size() == 0) begin
                checkOutput("B_unexpected_ack", int'(ackB), 0);
            end else begin
                eB = qB.pop_front();
                checkOutput($sformatf("B_ack_p%0d", eB.port), int'(ackB), 1 << eB.port);
                if (eB.cyc >= 0)
                    checkOutput($sformatf("B_ack_cycle_p%0d", eB.port), cyc, eB.cyc);
                checkOutput($sformatf("B_outport_p%0d", eB.port),
                            int'(outportB[eB.port*3 +: 3]), eB.dest);
                checkOutput($sformatf("B_inport_o%0d", eB.dest),
                            int'(inportB[eB.dest*3 +: 3]), eB.port);
                checkOutput($sformatf("B_free_o%0d", eB.dest), int'(freeB[eB.dest]), 0);
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 400000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rstA = 1'b1; rstB = 1'b1;
        reqA = '0; sendA = '0; dataA = '0;
        reqB = '0; sendB = '0; dataB = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_freeA", int'(freeA), 5'h1F);
        checkOutput("reset_ackA", int'(ackA), 0);
        checkOutput("reset_outportA", int'(outportA), 0);
        checkOutput("reset_inportA", int'(inportA), 0);
        checkOutput("reset_freeB", int'(freeB), 6'h3F);
        rstA = 1'b0; rstB = 1'b0;

        $display("[TB] XY: WEST input to target 0x0302 goes EAST");
        applyStimulus(0, 1, mkHead(0, 3'd0, 0, 16'h0302));
        sendA[1] = 1'b1;
        qA.push_back('{port: 1, dest: HERMES_EAST, cyc: cyc + 4});
        waitAckDrop(0, 1);

        $display("[TB] Blocked: SOUTH input wants busy EAST until WEST releases it");
        applyStimulus(0, 3, mkHead(0, 3'd0, 0, 16'h0501));
        sendA[3] = 1'b1;
        qA.push_back('{port: 3, dest: HERMES_EAST, cyc: -1});
        repeat (12) @(negedge clk);
        checkOutput("blocked_free_east", int'(freeA[0]), 0);
        checkOutput("blocked_pending", qA.size(), 1);
        sendA[1] = 1'b0;
        @(negedge clk);
        checkOutput("release_free_east", int'(freeA[0]), 1);
        waitAckDrop(0, 3);
        sendA[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("release_after_blocked", int'(freeA), 5'h1F);

        $display("[TB] Contention: p0 and p2 after reset, sel=0");
        rstA = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstA = 1'b0;
        for (int round = 0; round < 2; round++) begin
            applyStimulus(0, 0, mkHead(0, 3'd0, 0, 16'h0105));
            applyStimulus(0, 2, mkHead(0, 3'd0, 0, 16'h0001));
            qA.push_back('{port: 2, dest: HERMES_WEST, cyc: cyc + 4});
            qA.push_back('{port: 0, dest: HERMES_NORTH, cyc: cyc + 9});
            fork
                waitAckDrop(0, 2);
                waitAckDrop(0, 0);
            join
            sendA[0] = 1'b1; sendA[2] = 1'b1;
            @(negedge clk);
            sendA[0] = 1'b0; sendA[2] = 1'b0;
            @(negedge clk);
            checkOutput($sformatf("multi_release_r%0d", round), int'(freeA), 5'h1F);
        end

        $display("[TB] Forced out-of-range port then reset during ACK");
        applyStimulus(0, 4, mkHead(1, 3'd7, 0, 16'h0101));
        qA.push_back('{port: 4, dest: HERMES_LOCAL0, cyc: cyc + 4});
        n = 0;
        while (n < 40 && !ackA[4]) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midack_seen", int'(ackA[4]), 1);
        rstA = 1'b1;
        reqA[4] = 1'b0;
        @(negedge clk);
        checkOutput("midack_ack", int'(ackA), 0);
        checkOutput("midack_free", int'(freeA), 5'h1F);
        checkOutput("midack_outport", int'(outportA), 0);
        checkOutput("midack_inport", int'(inportA), 0);
        rstA = 1'b0;
        @(negedge clk);

        $display("[TB] YX router with two local ports");
        applyStimulus(1, 1, mkHead(0, 3'd0, 0, 16'h0302));
        qB.push_back('{port: 1, dest: HERMES_NORTH, cyc: cyc + 4});
        waitAckDrop(1, 1);
        applyStimulus(1, 0, mkHead(1, 3'd4, 0, 16'h0101));
        qB.push_back('{port: 0, dest: HERMES_LOCAL0, cyc: cyc + 4});
        waitAckDrop(1, 0);
        applyStimulus(1, 2, mkHead(0, 3'd0, 1, 16'h0101));
        qB.push_back('{port: 2, dest: HERMES_LOCAL0 + 1, cyc: cyc + 4});
        waitAckDrop(1, 2);
        applyStimulus(1, 3, mkHead(1, 3'd1, 0, 16'h0101));
        qB.push_back('{port: 3, dest: HERMES_WEST, cyc: cyc + 4});
        waitAckDrop(1, 3);
        applyStimulus(1, 4, mkHead(0, 3'd0, 0, 16'h0000));
        qB.push_back('{port: 4, dest: HERMES_SOUTH, cyc: cyc + 4});
        waitAckDrop(1, 4);

        repeat (3) @(negedge clk);
        checkOutput("queueA_drained", qA.size(), 0);
        checkOutput("queueB_drained", qB.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/hermes_route_ctrl.md
Name: hermes_route_ctrl

Overview:
Parametrised routing and switch-control unit for the Hermes router. It arbitrates header requests from NPORT = 4 + NLOCAL input ports and computes the output port by XY or YX dimension-ordered routing. It tracks output occupancy, drives crossbar select registers and acknowledges the granted input. It sits between the input buffers (req/sending/header data) and the crossbar in each router.

Parameters:
COORD_W, 8, bits per coordinate; ADDRESS and header target are 2*COORD_W wide.
NLOCAL, 1, number of local ports (1..4); NPORT = 4 + NLOCAL; PORT_W = $clog2(NPORT).
FLIT_SIZE, 32, flit width; must be >= 2*COORD_W + PORT_W + 1.
ADDRESS, 0, router coordinate; X in [2*COORD_W-1:COORD_W], Y in [COORD_W-1:0].
ROUTING, HERMES_XY, routing mode; HERMES_XY resolves X first, HERMES_YX resolves Y first.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  synchronous, active-high reset.
req_i  in  NPORT x 1  header pending at input p.
sending_i  in  NPORT x 1  input p is forwarding a packet; a 1->0 edge releases its output.
data_i  in  NPORT x FLIT_SIZE  head flit of input p.
ack_o  out  NPORT x 1  one-cycle grant acknowledge to the selected input.
free_o  out  NPORT x 1  output p is unallocated.
inport_o  out  NPORT x PORT_W  input connected to output p.
outport_o  out  NPORT x PORT_W  output allocated to input p.

Behaviour:
- Reset is synchronous and active-high: state=IDLE, sel=0, free_o all 1, inport_o/outport_o all 0 (EAST), ack_o all 0, sending_r all 0. A reset mid-packet drops all allocations.
- Port encoding: EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL0+k=4+k.
- Header fields: target X/Y in bits [2*COORD_W-1:0]; force=bit FLIT_SIZE-1; force_port=bits [FLIT_SIZE-2 -: PORT_W]; local index=bits [FLIT_SIZE-2-PORT_W -: $clog2(NLOCAL)] (zero-width when NLOCAL=1, index 0).
- FSM (one-hot): IDLE -> ARBIT when any req_i; ARBIT -> ROUTE; ROUTE -> GRANT if free_o[dest] else ARBIT; GRANT -> ACK; ACK -> IDLE.
- Round-robin in ARBIT: sel <= the first requesting port strictly after sel (wrapping); if none, the lowest requester; if none at all, sel is unchanged.
- Routing is combinational from data_i[sel]:
  - XY: X differs -> EAST if tgtX > myX else WEST; else Y differs -> NORTH if tgtY > myY else SOUTH; else local.
  - YX: same comparisons with Y resolved first.
  - Coordinates compare unsigned.
  - Local destination: force ? force_port : LOCAL0+index. A force_port >= NPORT or an index >= NLOCAL maps to LOCAL0.
- GRANT cycle (registered at its edge): free_o[dest]<=0, outport_o[sel]<=dest, inport_o[dest]<=sel.
- ACK: ack_o[sel]=1 for exactly that cycle; all other bits 0.
- Latency: req_i sampled in IDLE at cycle 0 gives ack at cycle 4 when dest is free. Each blocked ROUTE adds 2 cycles and re-arbitrates, so other requesters can overtake.
- Release: sending_r <= sending_i every cycle. sending_r[p] & ~sending_i[p] sets free_o[outport_o[p]]<=1.
  - Multiple releases in one cycle all apply.
  - A release and a GRANT in the same cycle on different outputs both apply.
  - A release and a GRANT targeting the same output cannot coincide, because GRANT requires free; the GRANT write takes precedence regardless.
- A req_i that drops while the FSM is past ARBIT is ignored; the sequence completes.

Decomposition:
- HermesPkg gains:
  - hermes_routing_t {HERMES_XY, HERMES_YX};
  - localparams HERMES_EAST..HERMES_SOUTH and HERMES_LOCAL0;
  - function hermes_nport(NLOCAL).
- Port values are logic [PORT_W-1:0], not a fixed enum.
- One sub-module: hermes_rr_arbiter (parameter N; inputs req, current sel, enable; output next sel), reusable by the buffer-side logic.

Test Plan:
- Reset: assert rst_i for 2 cycles -> free_o all 1, ack_o 0, inport_o/outport_o 0; state IDLE.
- XY, ADDRESS=0x0101, header on WEST (p1) targeting 0x0302 -> ack_o[1] at cycle 4, outport_o[1]=EAST, inport_o[0]=1, free_o[0]=0.
- YX, same header -> outport_o[1]=NORTH(2). Target 0x0101 with force=1, force_port=4 -> LOCAL0. NLOCAL=2 with index=1 -> port 5.
- Contention: p0 and p2 request simultaneously for different outputs with sel=0 -> p2 acked first, then p0; third round with p0, p2 -> p2 again.
- Blocked: output EAST busy; p1 requests EAST -> ROUTE->ARBIT loops with no ack. Drop sending_i of the holder -> free_o[0]=1 next cycle, then p1 acked.
- Reset mid-ACK: assert rst_i in the ACK cycle -> next cycle ack_o=0, free_o all 1, state IDLE.
